log2e_arbiter: RTL and testbench
================================

Name: log2e_arbiter

Overview:
- Shares one 2-stage mul_log2e datapath (FP32 x log2(e), for exp2-based softmax/exp lanes) among NUM_REQ requesters.
- Round-robin issue, one operation per cycle.
- Tracks each op's requester tag through the pipeline with its own valid/tag shift register.
- Returns results through a one-entry output register; backpressure stalls the shared pipeline via its enable.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
DATA_WIDTH, 32, operand/result width (FP32)
LAT, 2, datapath latency in enabled cycles
TAG_WIDTH, $clog2(NUM_REQ), requester index width (local parameter)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_valid  in  NUM_REQ  per-requester operand valid
req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
req_data  in  NUM_REQ*DATA_WIDTH  packed operands; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
rsp_valid  out  NUM_REQ  per-requester result valid (one-hot or zero)
rsp_ready  in  NUM_REQ  per-requester result accept
rsp_data  out  DATA_WIDTH  result, shared by all requesters
mul_op  out  DATA_WIDTH  datapath operand input
mul_vld_in  out  1  datapath vld_in
mul_en  out  1  datapath en
mul_result  in  DATA_WIDTH  datapath Result_out
mul_vld_out  in  1  datapath vld_out (unused for control)
perf_issue_cnt  out  32  issued-op counter (optional feature)
perf_stall_cnt  out  32  stall-cycle counter (optional feature)

Behaviour:
- Datapath vld_out is sticky after the first op and is not trusted. Completion comes only from the internal shift register: vld_sr[LAT-1:0] plus tag_sr, advanced only when mul_en=1.
- Output register: out_valid, out_tag, out_data.
  - rsp_valid[i] = out_valid & (out_tag==i).
  - rsp_data = out_data.
  - Drained when rsp_ready[out_tag] is high.
- Stall rule: mul_en = !out_valid | rsp_ready[out_tag]. Combinational; never depends on req_valid.
- Grant:
  - Combinational round-robin over req_valid, starting at index rr_ptr.
  - Active only when mul_en=1; otherwise req_ready=0.
  - req_ready = grant.
  - mul_vld_in = |grant.
  - mul_op = req_data of the granted requester; 0 when no grant.
- On a handshake to requester g: vld_sr[0]<=1, tag_sr[0]<=g, rr_ptr<=(g+1) mod NUM_REQ.
- With no grant and mul_en=1: vld_sr[0]<=0 (bubble). rr_ptr holds.
- Capture: when mul_en=1 and vld_sr[LAT-1]=1, out_valid<=1, out_tag<=tag_sr[LAT-1], out_data<=mul_result. This takes the same edge as any drain; capture overrides clear.
- Drain without capture: out_valid<=0.
- Latency: request accepted at edge t, rsp_valid asserted from cycle t+LAT+1 (3 with defaults). Throughput is 1 op/cycle when responses are drained every cycle.
- While stalled: the datapath, vld_sr, tag_sr, rr_ptr and the output register all hold; no requester sees req_ready.
- In-flight ops are bounded to LAT+1. No result is ever dropped or duplicated.
- Simultaneous drain and capture in the same cycle is legal, sustaining full throughput.
- Reset (any cycle, including mid-operation) sets:
  - vld_sr=0, out_valid=0, out_tag=0, out_data=0, rr_ptr=0.
  - Therefore rsp_valid=0, req_ready=0 during reset, mul_vld_in=0.
  - mul_en=1 after reset.
  - In-flight operations are discarded; datapath contents are don't-care.
- Combinational outputs are forced to 0 while rst=1.

Optional Feature:
- Macro LOG2E_ARB_PERF_CNT_EN.
- Defined:
  - perf_issue_cnt increments on every accepted request.
  - perf_stall_cnt increments every cycle with mul_en=0.
  - Both are 32-bit, wrap 0xFFFFFFFF->0, and reset to 0.
- Undefined: both ports tied to 0; no counter flops.

Test Plan:
- Single op: req 0 sends 0x3F800000, rsp_ready=all 1 -> rsp_valid[0] exactly 3 cycles after accept, rsp_data=0x3FB8AA3B. No other rsp_valid bits set.
- Round-robin: all 4 req_valid held, operands 0x3F800000/0x40000000/0xBF800000/0x00000000.
  - Grants 0,1,2,3,0 on consecutive cycles.
  - Responses in the same order with data 0x3FB8AA3B/0x4038AA3B/0xBFB8AA3B/0x00000000.
- Backpressure: stream on req 1, rsp_ready[1]=0 for 5 cycles.
  - mul_en=0 and req_ready=0 for those cycles; out_data held.
  - On release, results arrive in order with none lost or duplicated.
  - perf_stall_cnt=5 when the macro is defined.
- Full-throughput drain: 16 back-to-back ops with rsp_ready=1 -> 16 responses on 16 consecutive cycles, mul_en never deasserted.
- Reset mid-flight: assert rst one cycle with 2 ops in the pipeline and out_valid=1.
  - Next cycle: rsp_valid=0, rr_ptr=0.
  - Discarded results never appear.
  - A new op on req 2 returns correctly after 3 cycles.

Source files
------------

// File: rtl/log2e_arbiter.sv
// Round-robin arbiter sharing one 2-stage mul_log2e datapath among NUM_REQ requesters.
// Optional perf counters are enabled by defining LOG2E_ARB_PERF_CNT_EN.
module log2e_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int LAT        = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [DATA_WIDTH-1:0]         mul_op,
  output logic                          mul_vld_in,
  output logic                          mul_en,
  input  logic [DATA_WIDTH-1:0]         mul_result,
  input  logic                          mul_vld_out,
  output logic [31:0]                   perf_issue_cnt,
  output logic [31:0]                   perf_stall_cnt
);

  localparam int TAG_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [LAT-1:0]        vld_sr_q, vld_sr_d;
  logic [TAG_WIDTH-1:0]  tag_sr_q [LAT];
  logic [TAG_WIDTH-1:0]  tag_sr_d [LAT];
  logic [TAG_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
  logic                  out_valid_q, out_valid_d;
  logic [TAG_WIDTH-1:0]  out_tag_q, out_tag_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

  logic                  en;
  logic                  grant_any;
  logic [TAG_WIDTH-1:0]  grant_idx;

  // The datapath's own vld_out is sticky, so completion is tracked by vld_sr only.
  logic unused_vld_out;
  assign unused_vld_out = mul_vld_out;

  function automatic logic [TAG_WIDTH-1:0] wrap_add(input logic [TAG_WIDTH-1:0] base,
                                                     input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return TAG_WIDTH'(s);
  endfunction

  always_comb begin
    en = !out_valid_q || rsp_ready[out_tag_q];
  end

  always_comb begin
    grant_any = 1'b0;
    grant_idx = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_any && req_valid[wrap_add(rr_ptr_q, k)]) begin
        grant_any = 1'b1;
        grant_idx = wrap_add(rr_ptr_q, k);
      end
    end
    if (rst || !en) grant_any = 1'b0;
  end

  always_comb begin
    vld_sr_d    = vld_sr_q;
    tag_sr_d    = tag_sr_q;
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_tag_d   = out_tag_q;
    out_data_d  = out_data_q;
    if (en) begin
      vld_sr_d[0] = grant_any;
      if (grant_any) begin
        tag_sr_d[0] = grant_idx;
        rr_ptr_d    = wrap_add(grant_idx, 1);
      end
      for (int i = 1; i < LAT; i++) begin
        vld_sr_d[i] = vld_sr_q[i-1];
        tag_sr_d[i] = tag_sr_q[i-1];
      end
      // en with a valid output implies the holder is draining; a capture refills it.
      out_valid_d = vld_sr_q[LAT-1];
      if (vld_sr_q[LAT-1]) begin
        out_tag_d  = tag_sr_q[LAT-1];
        out_data_d = mul_result;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_sr_q    <= '0;
      for (int i = 0; i < LAT; i++) tag_sr_q[i] <= '0;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_tag_q   <= '0;
      out_data_q  <= '0;
    end else begin
      vld_sr_q    <= vld_sr_d;
      tag_sr_q    <= tag_sr_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_tag_q   <= out_tag_d;
      out_data_q  <= out_data_d;
    end
  end

  assign req_ready  = grant_any ? (NUM_REQ'(1) << grant_idx) : '0;
  assign mul_vld_in = grant_any;
  assign mul_op     = grant_any ? req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign mul_en     = en && !rst;
  assign rsp_valid  = (out_valid_q && !rst) ? (NUM_REQ'(1) << out_tag_q) : '0;
  assign rsp_data   = rst ? '0 : out_data_q;

`ifdef LOG2E_ARB_PERF_CNT_EN
  logic [31:0] issue_cnt_q, issue_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    issue_cnt_d = issue_cnt_q + 32'(grant_any);
    stall_cnt_d = stall_cnt_q + 32'(!en);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_issue_cnt = issue_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`else
  assign perf_issue_cnt = '0;
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_log2e_arbiter.sv
// Bench for log2e_arbiter: mock 2-stage datapath, cycle table, directed corner cases,
// and random traffic against a queue-based reference of the arbiter's behaviour.
module tb_log2e_arbiter;
  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*DW-1:0] req_data;
  logic [DW-1:0]   rsp_data, mul_op, mul_result;
  logic            mul_vld_in, mul_en, mul_vld_out;
  logic [31:0]     perf_issue_cnt, perf_stall_cnt;

  always #5 clk = ~clk;

  log2e_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .mul_op(mul_op), .mul_vld_in(mul_vld_in), .mul_en(mul_en),
    .mul_result(mul_result), .mul_vld_out(mul_vld_out),
    .perf_issue_cnt(perf_issue_cnt), .perf_stall_cnt(perf_stall_cnt));

  // Exact FP32 x log2(e) for the reference operands; a distinct stand-in elsewhere.
  function automatic logic [31:0] fmul(input logic [31:0] x);
    case (x)
      32'h3F80_0000: return 32'h3FB8_AA3B;
      32'h4000_0000: return 32'h4038_AA3B;
      32'hBF80_0000: return 32'hBFB8_AA3B;
      32'h0000_0000: return 32'h0000_0000;
      default:       return {x[31:24] ^ 8'h5A, x[23:0] + 24'h1};
    endcase
  endfunction

  logic [31:0] dp_s1 = '0, dp_s2 = '0;
  logic        dp_vld = 1'b0;
  always @(posedge clk) begin
    if (mul_en) begin
      dp_s1 <= fmul(mul_op);
      dp_s2 <= dp_s1;
      if (mul_vld_in) dp_vld <= 1'b1;
    end
  end
  assign mul_result  = dp_s2;
  assign mul_vld_out = dp_vld;

  int checks = 0, failures = 0, cyc = 0;
  logic [31:0] ops [N];
  logic [N-1:0] obs_ready, obs_rsp;
  logic [31:0]  obs_data;
  logic         obs_en;
  int acc_cnt, rsp_cnt, stall_obs;
  logic [31:0] sent_q[$], got_q[$];

  typedef struct { int tag; logic [31:0] op; int age; } inflight_t;
  inflight_t m_q[$];
  bit          m_out_v, m_en;
  int          m_out_tag, m_ptr, m_g;
  logic [31:0] m_out_data, m_issue, m_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic clear_stats();
    acc_cnt = 0; rsp_cnt = 0; stall_obs = 0;
    sent_q.delete(); got_q.delete();
  endtask

  task automatic cycle(input logic r, input logic [N-1:0] rv, input logic [N-1:0] rr);
    logic [N-1:0] e_ready = '0, e_rsp = '0;
    logic [31:0]  e_op = '0;
    inflight_t    it;
    rst = r; req_valid = rv; rsp_ready = rr;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = ops[i];
    #1;
    m_g = -1;
    if (r) m_en = 1'b0;
    else begin
      m_en = !m_out_v || rr[m_out_tag];
      if (m_en)
        for (int k = 0; k < N; k++)
          if (m_g < 0 && rv[(m_ptr + k) % N]) m_g = (m_ptr + k) % N;
      if (m_g >= 0) begin e_ready[m_g] = 1'b1; e_op = ops[m_g]; end
      if (m_out_v) e_rsp[m_out_tag] = 1'b1;
    end
    obs_ready = req_ready; obs_rsp = rsp_valid; obs_data = rsp_data; obs_en = mul_en;
    chk("req_ready", req_ready, e_ready);
    chk("rsp_valid", rsp_valid, e_rsp);
    chk("mul_en", mul_en, m_en);
    chk("mul_vld_in", mul_vld_in, m_g >= 0);
    chk("mul_op", mul_op, e_op);
    if (e_rsp != '0) chk("rsp_data", rsp_data, m_out_data);
`ifdef LOG2E_ARB_PERF_CNT_EN
    chk("perf_issue", perf_issue_cnt, m_issue);
    chk("perf_stall", perf_stall_cnt, m_stall);
`else
    chk("perf_issue", perf_issue_cnt, 32'd0);
    chk("perf_stall", perf_stall_cnt, 32'd0);
`endif
    if (!r) begin
      for (int k = 0; k < N; k++) begin
        if (req_ready[k] && req_valid[k]) begin acc_cnt++; sent_q.push_back(ops[k]); end
        if (rsp_valid[k] && rsp_ready[k]) begin rsp_cnt++; got_q.push_back(rsp_data); end
      end
      if (!mul_en) stall_obs++;
    end
    @(posedge clk);
    if (r) begin
      m_out_v = 1'b0; m_out_tag = 0; m_out_data = '0; m_ptr = 0;
      m_q.delete(); m_issue = '0; m_stall = '0;
    end else if (m_en) begin
      if (m_q.size() > 0 && m_q[0].age == LAT) begin
        m_out_v = 1'b1; m_out_tag = m_q[0].tag; m_out_data = fmul(m_q[0].op);
        void'(m_q.pop_front());
      end else m_out_v = 1'b0;
      foreach (m_q[i]) m_q[i].age++;
      if (m_g >= 0) begin
        it.tag = m_g; it.op = ops[m_g]; it.age = 1;
        m_q.push_back(it);
        m_ptr = (m_g + 1) % N;
        m_issue++;
      end
    end else m_stall++;
    cyc++;
    #1;
  endtask

  typedef struct {
    logic r; logic [N-1:0] rv, rr, exp_ready, exp_rsp; logic [31:0] exp_data; logic exp_en;
  } vec_t;
  vec_t tbl [10];

  initial begin
    logic [31:0] held;
    int first_rsp, last_rsp, rsp2_at;
    rst = 1'b1; req_valid = '0; rsp_ready = '0; req_data = '0;
    for (int i = 0; i < N; i++) ops[i] = '0;
    m_out_v = 1'b0; m_out_tag = 0; m_out_data = '0; m_ptr = 0; m_issue = '0; m_stall = '0;
    clear_stats();
    @(posedge clk); #1;

    // Round-robin with all four held, then responses in grant order.
    ops[0] = 32'h3F80_0000; ops[1] = 32'h4000_0000; ops[2] = 32'hBF80_0000; ops[3] = 32'h0;
    tbl[0] = '{1'b1, 4'hF, 4'hF, 4'h0, 4'h0, 32'h0,         1'b0};
    tbl[1] = '{1'b0, 4'hF, 4'hF, 4'h1, 4'h0, 32'h0,         1'b1};
    tbl[2] = '{1'b0, 4'hF, 4'hF, 4'h2, 4'h0, 32'h0,         1'b1};
    tbl[3] = '{1'b0, 4'hF, 4'hF, 4'h4, 4'h0, 32'h0,         1'b1};
    tbl[4] = '{1'b0, 4'hF, 4'hF, 4'h8, 4'h1, 32'h3FB8_AA3B, 1'b1};
    tbl[5] = '{1'b0, 4'hF, 4'hF, 4'h1, 4'h2, 32'h4038_AA3B, 1'b1};
    tbl[6] = '{1'b0, 4'h0, 4'hF, 4'h0, 4'h4, 32'hBFB8_AA3B, 1'b1};
    tbl[7] = '{1'b0, 4'h0, 4'hF, 4'h0, 4'h8, 32'h0000_0000, 1'b1};
    tbl[8] = '{1'b0, 4'h0, 4'hF, 4'h0, 4'h1, 32'h3FB8_AA3B, 1'b1};
    tbl[9] = '{1'b0, 4'h0, 4'hF, 4'h0, 4'h0, 32'h0,         1'b1};
    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].r, tbl[i].rv, tbl[i].rr);
      chk($sformatf("tbl%0d_ready", i), obs_ready, tbl[i].exp_ready);
      chk($sformatf("tbl%0d_rsp", i), obs_rsp, tbl[i].exp_rsp);
      chk($sformatf("tbl%0d_en", i), obs_en, tbl[i].exp_en);
      if (tbl[i].exp_rsp != '0) chk($sformatf("tbl%0d_data", i), obs_data, tbl[i].exp_data);
    end

    // Single op on requester 0: visible exactly three cycles after the accept cycle.
    cycle(1'b1, 4'h0, 4'hF);
    ops[0] = 32'h3F80_0000;
    cycle(1'b0, 4'h1, 4'hF);
    chk("single_accept", obs_ready, 4'h1);
    cycle(1'b0, 4'h0, 4'hF); chk("single_early1", obs_rsp, 4'h0);
    cycle(1'b0, 4'h0, 4'hF); chk("single_early2", obs_rsp, 4'h0);
    cycle(1'b0, 4'h0, 4'hF);
    chk("single_rsp", obs_rsp, 4'h1);
    chk("single_data", obs_data, 32'h3FB8_AA3B);
    cycle(1'b0, 4'h0, 4'hF); chk("single_once", obs_rsp, 4'h0);

    // Backpressure on requester 1 for five cycles.
    cycle(1'b1, 4'h0, 4'hF);
    clear_stats();
    for (int i = 0; i < 4; i++) begin
      ops[1] = 32'h4100_0000 + 32'(i);
      cycle(1'b0, 4'h2, 4'hF);
    end
    held = '0;
    for (int j = 0; j < 5; j++) begin
      ops[1] = 32'h4200_0000 + 32'(j);
      cycle(1'b0, 4'h2, 4'hD);
      if (j == 0) held = obs_data;
      chk("bp_en", obs_en, 1'b0);
      chk("bp_ready", obs_ready, 4'h0);
      chk("bp_hold", obs_data, fmul(32'h4100_0001));
      chk("bp_hold_same", obs_data, held);
    end
    for (int i = 0; i < 8; i++) cycle(1'b0, 4'h0, 4'hF);
    chk("bp_stall_cycles", stall_obs, 5);
    chk("bp_count", got_q.size(), sent_q.size());
    chk("bp_sent", sent_q.size(), 4);
    for (int i = 0; i < got_q.size() && i < sent_q.size(); i++)
      chk($sformatf("bp_order%0d", i), got_q[i], fmul(sent_q[i]));
`ifdef LOG2E_ARB_PERF_CNT_EN
    chk("bp_perf_stall", perf_stall_cnt, 32'd5);
`endif

    // Sixteen back-to-back ops drained every cycle.
    cycle(1'b1, 4'h0, 4'hF);
    clear_stats();
    first_rsp = -1; last_rsp = -1;
    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < N; k++) ops[k] = $urandom;
      cycle(1'b0, (i < 16) ? 4'hF : 4'h0, 4'hF);
      if (obs_rsp != '0) begin
        if (first_rsp < 0) first_rsp = i;
        last_rsp = i;
      end
    end
    chk("ft_accepts", acc_cnt, 16);
    chk("ft_rsps", rsp_cnt, 16);
    chk("ft_first", first_rsp, 3);
    chk("ft_span", last_rsp - first_rsp, 15);
    chk("ft_no_stall", stall_obs, 0);

    // Reset with two ops in flight and a full output register.
    cycle(1'b1, 4'h0, 4'hF);
    ops[0] = 32'h1111_1111; cycle(1'b0, 4'h1, 4'hF);
    ops[0] = 32'h2222_2222; cycle(1'b0, 4'h1, 4'hF);
    ops[0] = 32'h3333_3333; cycle(1'b0, 4'h1, 4'hF);
    cycle(1'b1, 4'hF, 4'hF);
    chk("rst_ready", obs_ready, 4'h0);
    chk("rst_rsp", obs_rsp, 4'h0);
    clear_stats();
    ops[0] = 32'h3F80_0000; ops[2] = 32'h4000_0000;
    cycle(1'b0, 4'h5, 4'hF);
    chk("rst_ptr0", obs_ready, 4'h1);
    chk("rst_rsp_after", obs_rsp, 4'h0);
    cycle(1'b0, 4'h4, 4'hF);
    chk("rst_req2", obs_ready, 4'h4);
    rsp2_at = -1;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 4'h0, 4'hF);
      if (obs_rsp[2]) rsp2_at = i;
    end
    chk("rst_rsp_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("rst_rsp0", got_q[0], 32'h3FB8_AA3B);
      chk("rst_rsp2", got_q[1], 32'h4038_AA3B);
    end
    chk("rst_rsp2_latency", rsp2_at, 2);

    // Random traffic against the reference model.
    cycle(1'b1, 4'h0, 4'hF);
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < N; k++) ops[k] = $urandom;
      cycle($urandom_range(0, 79) == 0, 4'($urandom),
            ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
